// File: rtl/mixed_encoder_low.sv
// Registered 4-to-2 priority encoder for active-low request lines.
// Each falling edge on a synchronised req_n line becomes a pending event;
// pending events are drained one code per handshake in priority order.
module mixed_encoder_low #(
    parameter int SYNC_STAGES = 2,    // synchroniser depth on req_n, 2..4
    parameter bit PRIO_HIGH   = 1'b0  // 0: lowest index first, 1: highest index first
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req_n,
    input  logic       out_ready,
    output logic       out_valid,
    output logic [1:0] code,
    output logic       multi,
    output logic       ovf
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t     state;
    state_t     state_nxt;

    logic [3:0] sync_q [SYNC_STAGES];
    logic [3:0] s;
    logic [3:0] prev;
    logic [3:0] evt;

    logic [3:0] pend;
    logic [3:0] pend_nxt;
    logic [3:0] grant_clr;
    logic [1:0] sel;
    logic [1:0] code_nxt;
    logic       multi_nxt;
    logic       ovf_nxt;
    logic       load;

    // Priority pick over a request vector; the direction is fixed by PRIO_HIGH.
    function automatic logic [1:0] pick(input logic [3:0] v);
        logic [1:0] r;
        r = 2'd0;
        if (PRIO_HIGH) begin
            for (int i = 0; i < 4; i++) begin
                if (v[i]) r = i[1:0];
            end
        end else begin
            for (int i = 3; i >= 0; i--) begin
                if (v[i]) r = i[1:0];
            end
        end
        return r;
    endfunction

    // True when more than one bit of v is set.
    function automatic logic several(input logic [3:0] v);
        return (v & (v - 4'd1)) != 4'd0;
    endfunction

    assign s         = sync_q[SYNC_STAGES-1];
    assign evt       = prev & ~s;  // high->low on the synchronised line
    assign out_valid = (state == HOLD);

    // Synchroniser chain plus one-cycle-old copy for edge detection; idle level is all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= 4'b1111;
            end
            prev <= 4'b1111;
        end else begin
            sync_q[0] <= req_n;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            prev <= s;
        end
    end

    // Next-state, code load and pending-set update; a new event beats the grant clear.
    always_comb begin
        state_nxt = state;
        code_nxt  = code;
        multi_nxt = multi;
        grant_clr = 4'b0000;
        load      = 1'b0;
        sel       = pick(pend);

        case (state)
            IDLE: begin
                if (pend != 4'b0000) load = 1'b1;
            end
            HOLD: begin
                if (out_ready) begin
                    if (pend != 4'b0000) load = 1'b1;
                    else                 state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (load) begin
            state_nxt = HOLD;
            code_nxt  = sel;
            multi_nxt = several(pend);
            grant_clr = 4'b0001 << sel;
        end

        pend_nxt = evt | (pend & ~grant_clr);
        ovf_nxt  = ovf | (|(evt & pend & ~grant_clr));
    end

    // Control and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            pend  <= 4'b0000;
            code  <= 2'd0;
            multi <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            state <= state_nxt;
            pend  <= pend_nxt;
            code  <= code_nxt;
            multi <= multi_nxt;
            ovf   <= ovf_nxt;
        end
    end

endmodule

// File: tb/tb_mixed_encoder_low.sv
// Bench for mixed_encoder_low: a vector table, hand-written corner sequences,
// and a randomized run compared against an event-level reference model.
module tb_mixed_encoder_low;

    localparam int SS = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req_n = 4'b1111;
    logic       out_ready = 1'b0;

    logic       vld0, vld1;
    logic [1:0] code0, code1;
    logic       mul0, mul1;
    logic       ovf0, ovf1;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mixed_encoder_low #(.SYNC_STAGES(SS), .PRIO_HIGH(1'b0)) dut_lo (
        .clk(clk), .rst_n(rst_n), .req_n(req_n), .out_ready(out_ready),
        .out_valid(vld0), .code(code0), .multi(mul0), .ovf(ovf0)
    );

    mixed_encoder_low #(.SYNC_STAGES(SS), .PRIO_HIGH(1'b1)) dut_hi (
        .clk(clk), .rst_n(rst_n), .req_n(req_n), .out_ready(out_ready),
        .out_valid(vld1), .code(code1), .multi(mul1), .ovf(ovf1)
    );

    // Reference model state: req_n history, pending set per priority flavour,
    // and the currently presented output.
    logic [3:0] m_hist [SS+1];
    logic [3:0] m_pend [2];
    logic       m_vld  [2];
    logic [1:0] m_code [2];
    logic       m_mul  [2];
    logic       m_ovf  [2];
    bit         model_on = 1'b0;

    task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int j = 0; j <= SS; j++) m_hist[j] = 4'b1111;
        for (int p = 0; p < 2; p++) begin
            m_pend[p] = 4'b0000;
            m_vld[p]  = 1'b0;
            m_code[p] = 2'd0;
            m_mul[p]  = 1'b0;
            m_ovf[p]  = 1'b0;
        end
    endtask

    // One clock edge of the reference behaviour, given the inputs seen at that edge.
    task automatic model_step(input logic [3:0] r, input logic rd);
        logic [3:0] sv, pv, ev, clr;
        int idx;
        sv = m_hist[SS-1];
        pv = m_hist[SS];
        ev = pv & ~sv;
        for (int p = 0; p < 2; p++) begin
            clr = 4'b0000;
            if (!m_vld[p] || rd) begin
                if (m_pend[p] != 4'b0000) begin
                    idx = -1;
                    for (int k = 0; k < 4; k++) begin
                        int b;
                        b = (p == 0) ? k : 3 - k;
                        if (idx < 0 && m_pend[p][b]) idx = b;
                    end
                    m_code[p] = idx[1:0];
                    m_mul[p]  = ($countones(m_pend[p]) > 1);
                    clr[idx]  = 1'b1;
                    m_vld[p]  = 1'b1;
                end else begin
                    m_vld[p] = 1'b0;
                end
            end
            if ((ev & m_pend[p] & ~clr) != 4'b0000) m_ovf[p] = 1'b1;
            m_pend[p] = ev | (m_pend[p] & ~clr);
        end
        for (int j = SS; j > 0; j--) m_hist[j] = m_hist[j-1];
        m_hist[0] = r;
    endtask

    // Drive inputs on the falling edge, let one rising edge pass, settle.
    task automatic cyc(input logic [3:0] r, input logic rd);
        @(negedge clk);
        req_n     = r;
        out_ready = rd;
        @(posedge clk);
        if (model_on) model_step(r, rd);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        req_n     = 4'b1111;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    typedef struct {
        logic [3:0] req;
        logic       rdy;
        logic       vld;
        logic [1:0] c_lo;
        logic [1:0] c_hi;
        logic       mul;
    } vec_t;

    vec_t tbl [20];

    initial begin
        logic [3:0] cur;
        logic       rd;
        int         n2;

        // single request on line 2, then simultaneous lines 0 and 3
        tbl[0]  = '{4'b1111, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0};
        tbl[1]  = '{4'b1011, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0};
        tbl[2]  = '{4'b1011, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0};
        tbl[3]  = '{4'b1011, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0};
        tbl[4]  = '{4'b1011, 1'b1, 1'b1, 2'd2, 2'd2, 1'b0};
        tbl[5]  = '{4'b1011, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0};
        tbl[6]  = '{4'b1011, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0};
        tbl[7]  = '{4'b1011, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0};
        tbl[8]  = '{4'b1111, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0};
        tbl[9]  = '{4'b1111, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0};
        tbl[10] = '{4'b1111, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0};
        tbl[11] = '{4'b0110, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0};
        tbl[12] = '{4'b0110, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0};
        tbl[13] = '{4'b0110, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0};
        tbl[14] = '{4'b0110, 1'b1, 1'b1, 2'd0, 2'd3, 1'b1};
        tbl[15] = '{4'b0110, 1'b1, 1'b1, 2'd3, 2'd0, 1'b0};
        tbl[16] = '{4'b0110, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0};
        tbl[17] = '{4'b1111, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0};
        tbl[18] = '{4'b1111, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0};
        tbl[19] = '{4'b1111, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0};

        // reset state while held in reset
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        chk("rst_vld", {3'b0, vld0}, 4'd0);
        chk("rst_code", {2'b0, code0}, 4'd0);
        chk("rst_multi", {3'b0, mul0}, 4'd0);
        chk("rst_ovf", {3'b0, ovf0}, 4'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // table vectors, both priority directions
        for (int i = 0; i < 20; i++) begin
            cyc(tbl[i].req, tbl[i].rdy);
            chk($sformatf("tbl%0d_vld_lo", i), {3'b0, vld0}, {3'b0, tbl[i].vld});
            chk($sformatf("tbl%0d_vld_hi", i), {3'b0, vld1}, {3'b0, tbl[i].vld});
            if (tbl[i].vld) begin
                chk($sformatf("tbl%0d_code_lo", i), {2'b0, code0}, {2'b0, tbl[i].c_lo});
                chk($sformatf("tbl%0d_code_hi", i), {2'b0, code1}, {2'b0, tbl[i].c_hi});
                chk($sformatf("tbl%0d_multi", i), {3'b0, mul0}, {3'b0, tbl[i].mul});
            end
            chk($sformatf("tbl%0d_ovf", i), {3'b0, ovf0}, 4'd0);
        end

        // reset in the middle of a held transfer with lines 1,2 still pending
        do_reset();
        repeat (4) cyc(4'b1000, 1'b0);
        chk("t1_vld", {3'b0, vld0}, 4'd1);
        chk("t1_code", {2'b0, code0}, 4'd0);
        chk("t1_multi", {3'b0, mul0}, 4'd1);
        repeat (2) cyc(4'b1000, 1'b0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        req_n = 4'b1111;
        #1;
        chk("t1_rst_vld", {3'b0, vld0}, 4'd0);
        chk("t1_rst_code", {2'b0, code0}, 4'd0);
        chk("t1_rst_multi", {3'b0, mul0}, 4'd0);
        chk("t1_rst_ovf", {3'b0, ovf0}, 4'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cyc(4'b1111, 1'b1);
            chk("t1_quiet_vld", {3'b0, vld0}, 4'd0);
        end
        repeat (3) cyc(4'b1011, 1'b1);
        chk("t1_new_early", {3'b0, vld0}, 4'd0);
        cyc(4'b1011, 1'b1);
        chk("t1_new_vld", {3'b0, vld0}, 4'd1);
        chk("t1_new_code", {2'b0, code0}, 4'd2);
        cyc(4'b1011, 1'b1);
        chk("t1_new_done", {3'b0, vld0}, 4'd0);

        // backpressure: code held while another line falls
        do_reset();
        repeat (4) cyc(4'b1101, 1'b0);
        chk("t4_vld", {3'b0, vld0}, 4'd1);
        chk("t4_code", {2'b0, code0}, 4'd1);
        for (int i = 0; i < 10; i++) begin
            cyc(4'b0101, 1'b0);
            chk("t4_hold_vld", {3'b0, vld0}, 4'd1);
            chk("t4_hold_code", {2'b0, code0}, 4'd1);
            chk("t4_hold_multi", {3'b0, mul0}, 4'd0);
        end
        cyc(4'b0101, 1'b1);
        chk("t4_next_vld", {3'b0, vld0}, 4'd1);
        chk("t4_next_code", {2'b0, code0}, 4'd3);
        chk("t4_next_multi", {3'b0, mul0}, 4'd0);
        cyc(4'b0101, 1'b1);
        chk("t4_idle", {3'b0, vld0}, 4'd0);

        // overflow: line 2 falls twice while code 0 is held
        do_reset();
        repeat (4) cyc(4'b1110, 1'b0);
        chk("t5_code0", {2'b0, code0}, 4'd0);
        repeat (3) cyc(4'b1010, 1'b0);
        repeat (3) cyc(4'b1110, 1'b0);
        repeat (3) cyc(4'b1010, 1'b0);
        repeat (5) cyc(4'b1110, 1'b0);
        chk("t5_ovf", {3'b0, ovf0}, 4'd1);
        chk("t5_hold_code", {2'b0, code0}, 4'd0);
        n2 = 0;
        for (int i = 0; i < 8; i++) begin
            cyc(4'b1110, 1'b1);
            if (vld0 && code0 == 2'd2) n2++;
        end
        chk("t5_code2_count", n2[3:0], 4'd1);
        chk("t5_ovf_sticky", {3'b0, ovf0}, 4'd1);

        // set wins over the grant clear on line 1
        do_reset();
        repeat (4) cyc(4'b1100, 1'b0);
        chk("t6_first_code", {2'b0, code0}, 4'd0);
        chk("t6_first_multi", {3'b0, mul0}, 4'd1);
        repeat (2) cyc(4'b1110, 1'b0);
        cyc(4'b1100, 1'b0);
        cyc(4'b1100, 1'b0);
        cyc(4'b1100, 1'b1);
        chk("t6_a_vld", {3'b0, vld0}, 4'd1);
        chk("t6_a_code", {2'b0, code0}, 4'd1);
        cyc(4'b1100, 1'b1);
        chk("t6_b_vld", {3'b0, vld0}, 4'd1);
        chk("t6_b_code", {2'b0, code0}, 4'd1);
        chk("t6_b_multi", {3'b0, mul0}, 4'd0);
        cyc(4'b1100, 1'b1);
        chk("t6_idle", {3'b0, vld0}, 4'd0);
        chk("t6_ovf", {3'b0, ovf0}, 4'd0);

        // randomized traffic against the reference model
        do_reset();
        model_on = 1'b1;
        cur = 4'b1111;
        for (int i = 0; i < 812; i++) begin
            if (i < 800) begin
                cur = cur ^ (4'($urandom) & 4'($urandom));
                rd  = ($urandom_range(0, 3) != 0);
            end else begin
                cur = 4'b1111;
                rd  = 1'b1;
            end
            cyc(cur, rd);
            chk("rnd_vld_lo", {3'b0, vld0}, {3'b0, m_vld[0]});
            chk("rnd_vld_hi", {3'b0, vld1}, {3'b0, m_vld[1]});
            chk("rnd_ovf_lo", {3'b0, ovf0}, {3'b0, m_ovf[0]});
            chk("rnd_ovf_hi", {3'b0, ovf1}, {3'b0, m_ovf[1]});
            if (m_vld[0]) begin
                chk("rnd_code_lo", {2'b0, code0}, {2'b0, m_code[0]});
                chk("rnd_multi_lo", {3'b0, mul0}, {3'b0, m_mul[0]});
            end
            if (m_vld[1]) begin
                chk("rnd_code_hi", {2'b0, code1}, {2'b0, m_code[1]});
                chk("rnd_multi_hi", {3'b0, mul1}, {3'b0, m_mul[1]});
            end
        end
        model_on = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
